// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration-chain loader:
// register offsets, control/status bit positions and FSM states.
package cfg_loader_pkg;

  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_LEN    = 3'd1;
  localparam logic [2:0] ADR_DIV    = 3'd2;
  localparam logic [2:0] ADR_DATA   = 3'd3;
  localparam logic [2:0] ADR_STATUS = 3'd4;
  localparam logic [2:0] ADR_TAIL   = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_PRST  = 2;
  localparam int CTRL_CSEL  = 3;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_LVL   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

endpackage

// File: rtl/cfg_word_fifo.sv
// Show-ahead word FIFO with level count and synchronous flush.
// A push while full is dropped; the caller flags the overflow.
module cfg_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone-mapped loader that streams FIFO words into ccff chains
// under a divided prog_clk, capturing chain-0 returns into TAIL.
module fpga_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  prog_clk,
  output logic                  prog_reset,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  clk_sel
);

  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int SHIFTS = 32 / NUM_CHAINS;

  state_t state, state_n;

  logic [2:0]  adr;
  logic        req, wr;
  logic        wr_ctrl, wr_len, wr_div;
  logic        wr_data, wr_stat;
  logic        start, abort;
  logic [31:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic        done_q, ovf_q;
  logic [31:0] tail_q;
  logic [31:0] rdata, status;

  logic [DIV_W-1:0] run_div, div_cnt;
  logic [31:0] remain, shreg;
  logic [5:0]  sh_cnt;
  logic [NUM_CHAINS-1:0] head_q;
  logic        phase_end, busy, pop;

  logic [31:0] f_rdata;
  logic        f_full, f_empty;
  logic [LW-1:0] f_level;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:5],
                         wbs_adr_i[1:0], ccff_tail};

  assign adr     = wbs_adr_i[4:2];
  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign wr_ctrl = wr && adr == ADR_CTRL;
  assign wr_len  = wr && adr == ADR_LEN;
  assign wr_div  = wr && adr == ADR_DIV;
  assign wr_data = wr && adr == ADR_DATA;
  assign wr_stat = wr && adr == ADR_STATUS;
  assign abort   = wr_ctrl & wbs_dat_i[CTRL_ABORT];
  assign start   = wr_ctrl & wbs_dat_i[CTRL_START];

  assign busy      = state inside {S_LOAD, S_LOW, S_HIGH};
  assign phase_end = (div_cnt == run_div);
  assign ccff_head = head_q;

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (abort),
    .push  (wr_data),
    .wdata (wbs_dat_i),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_n;
  end

  // Abort overrides every transition, including a same-write start.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (start)
            state_n = (len_q == '0) ? S_DONE : S_LOAD;
        S_LOAD:
          if (!f_empty) begin
            pop     = 1'b1;
            state_n = S_LOW;
          end
        S_LOW:
          if (phase_end) state_n = S_HIGH;
        S_HIGH:
          if (phase_end) begin
            if (remain == '0)
              state_n = S_DONE;
            else if (sh_cnt == 6'(SHIFTS))
              state_n = S_LOAD;
            else
              state_n = S_LOW;
          end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Head is held from the LOW entry through HIGH so it is stable
  // across the prog_clk rise, while shreg already advanced.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      run_div  <= '0;
      div_cnt  <= '0;
      remain   <= '0;
      shreg    <= '0;
      sh_cnt   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      prog_clk <= 1'b0;
    end else begin
      prog_clk <= (state_n == S_HIGH);
      if (state == S_IDLE && start && !abort) begin
        remain  <= len_q;
        run_div <= div_q;
      end
      if (state_n != state)
        div_cnt <= '0;
      else if (state == S_LOW || state == S_HIGH)
        div_cnt <= div_cnt + DIV_W'(1);
      if (pop) begin
        shreg  <= f_rdata;
        sh_cnt <= '0;
      end
      if (state == S_LOW && state_n == S_HIGH) begin
        shreg  <= shreg >> NUM_CHAINS;
        remain <= remain - 32'd1;
        sh_cnt <= sh_cnt + 6'd1;
        tail_q <= {ccff_tail[0], tail_q[31:1]};
      end
      if (state_n == S_LOW)
        head_q <= pop ? f_rdata[NUM_CHAINS-1:0]
                      : shreg[NUM_CHAINS-1:0];
      else if (state_n != S_HIGH)
        head_q <= '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      len_q      <= '0;
      div_q      <= '0;
      prog_reset <= 1'b0;
      clk_sel    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        prog_reset <= wbs_dat_i[CTRL_PRST];
        clk_sel    <= wbs_dat_i[CTRL_CSEL];
      end
      if (wr_len) len_q <= wbs_dat_i;
      if (wr_div) div_q <= wbs_dat_i[DIV_W-1:0];
      if (state_n == S_DONE && state != S_DONE)
        done_q <= 1'b1;
      else if (wr_stat && wbs_dat_i[ST_DONE])
        done_q <= 1'b0;
      if (wr_data && f_full)
        ovf_q <= 1'b1;
      else if (wr_stat && wbs_dat_i[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done_q;
    status[ST_FULL]  = f_full;
    status[ST_EMPTY] = f_empty;
    status[ST_OVF]   = ovf_q;
    status[ST_LVL+:8] = 8'(f_level);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (adr == ADR_CTRL):
        rdata = {28'd0, clk_sel, prog_reset, 2'b00};
      (adr == ADR_LEN):    rdata = len_q;
      (adr == ADR_DIV):    rdata = 32'(div_q);
      (adr == ADR_STATUS): rdata = status;
      (adr == ADR_TAIL):   rdata = tail_q;
      default:             rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: a single-chain and a
// dual-chain instance share one Wishbone bus.
module tb_fpga_cfg_loader;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_LEN  = 3'd1;
  localparam logic [2:0] A_DIV  = 3'd2;
  localparam logic [2:0] A_DATA = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;
  localparam logic [2:0] A_TAIL = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hf;
  logic [31:0] adr = '0, wdat = '0;
  logic ack1, ack2;
  logic [31:0] rdat1, rdat2;
  logic pc1, pc2, prst1, prst2, csel1, csel2;
  logic [0:0] head1, tail1;
  logic [1:0] head2;
  logic tail_d = 1'b0;
  logic loop_en = 1'b0;

  int total = 0;
  int bad = 0;

  int r1, r2, hi_cycles, hi_run, lo_run;
  int hi_min, hi_max, gap_min, gap_max;
  logic [63:0] h1bits, h2c0, h2c1;
  logic [31:0] q;

  always #5 clk = ~clk;

  assign tail1 = tail_d;
  always @(posedge pc1) tail_d <= loop_en ? head1[0] : 1'b0;

  fpga_cfg_loader #(
    .NUM_CHAINS (1), .FIFO_DEPTH (8), .DIV_W (8)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we),
    .wbs_sel_i (sel), .wbs_adr_i (adr), .wbs_dat_i (wdat),
    .wbs_ack_o (ack1), .wbs_dat_o (rdat1),
    .prog_clk (pc1), .prog_reset (prst1),
    .ccff_head (head1), .ccff_tail (tail1),
    .clk_sel (csel1)
  );

  fpga_cfg_loader #(
    .NUM_CHAINS (2), .FIFO_DEPTH (8), .DIV_W (8)
  ) dut2 (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we),
    .wbs_sel_i (sel), .wbs_adr_i (adr), .wbs_dat_i (wdat),
    .wbs_ack_o (ack2), .wbs_dat_o (rdat2),
    .prog_clk (pc2), .prog_reset (prst2),
    .ccff_head (head2), .ccff_tail (2'b00),
    .clk_sel (csel2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [2:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rq);
    logic got;
    got = 1'b0;
    rq  = '0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w;
    adr = {27'd0, a, 2'b00}; wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack1) begin
        got = 1'b1;
        rq  = rdat1;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, a, d, dummy);
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a,
                       input logic [31:0] exp);
    logic [31:0] v;
    xfer(1'b0, a, 32'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic prep();
    wr(A_CTRL, 32'h2);
    wr(A_STAT, 32'h12);
  endtask

  task automatic mon(input int n);
    logic p1, p2;
    r1 = 0; r2 = 0; hi_cycles = 0;
    hi_run = 0; lo_run = 0;
    hi_min = 1000; hi_max = 0;
    gap_min = 1000; gap_max = 0;
    h1bits = '0; h2c0 = '0; h2c1 = '0;
    p1 = pc1; p2 = pc2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!pc1 && p1) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run = 0;
      end
      if (pc1 && !p1) begin
        if (r1 > 0) begin
          if (lo_run < gap_min) gap_min = lo_run;
          if (lo_run > gap_max) gap_max = lo_run;
        end
        if (r1 < 64) h1bits[r1] = head1[0];
        r1++;
        hi_run = 0;
      end
      if (pc1) begin
        hi_run++;
        hi_cycles++;
      end else begin
        lo_run++;
      end
      if (pc2 && !p2) begin
        if (r2 < 64) begin
          h2c0[r2] = head2[0];
          h2c1[r2] = head2[1];
        end
        r2++;
      end
      p1 = pc1; p2 = pc2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_pins", {27'd0, ack1, pc1, prst1, csel1, head1},
        32'd0);
    rdchk("rst_status", A_STAT, 32'h08);
    rdchk("rst_len", A_LEN, 32'd0);
    rdchk("rst_div", A_DIV, 32'd0);
    rdchk("rst_tail", A_TAIL, 32'd0);

    // single chain, DIV=1, LEN=8, word 0xA5
    wr(A_DIV, 32'd1);
    wr(A_LEN, 32'd8);
    rdchk("t1_len", A_LEN, 32'd8);
    wr(A_DATA, 32'h0000_00A5);
    wr(A_CTRL, 32'h1);
    mon(60);
    chk("t1_rises", r1, 32'd8);
    chk("t1_bits", {24'd0, h1bits[7:0]}, 32'h0000_00A5);
    chk("t1_hi_min", hi_min, 32'd2);
    chk("t1_hi_max", hi_max, 32'd2);
    chk("t1_gap_min", gap_min, 32'd2);
    chk("t1_gap_max", gap_max, 32'd2);
    rdchk("t1_status", A_STAT, 32'h0A);

    // dual chain, LEN=16, word 0xFFFF0000
    prep();
    wr(A_DIV, 32'd0);
    wr(A_LEN, 32'd16);
    wr(A_DATA, 32'hFFFF_0000);
    wr(A_CTRL, 32'h1);
    mon(60);
    chk("t2_rises", r2, 32'd16);
    chk("t2_chain0", {16'd0, h2c0[15:0]}, 32'h0000_FF00);
    chk("t2_chain1", {16'd0, h2c1[15:0]}, 32'h0000_FF00);

    // FIFO underflow stall, LEN=64
    prep();
    wr(A_LEN, 32'd64);
    wr(A_DATA, 32'h5555_AAAA);
    wr(A_CTRL, 32'h1);
    mon(100);
    chk("t3_first_rises", r1, 32'd32);
    mon(200);
    chk("t3_stall_rises", r1, 32'd0);
    chk("t3_stall_high", hi_cycles, 32'd0);
    rdchk("t3_stall_status", A_STAT, 32'h09);
    wr(A_DATA, 32'h0F0F_F0F0);
    mon(100);
    chk("t3_second_rises", r1, 32'd32);
    rdchk("t3_status", A_STAT, 32'h0A);

    // overflow with the FSM idle
    prep();
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'(i));
    rdchk("t4_ovf_status", A_STAT, 32'h0814);
    wr(A_STAT, 32'h10);
    rdchk("t4_ovf_clear", A_STAT, 32'h0804);

    // abort and start in the same write
    prep();
    wr(A_DATA, 32'h1);
    wr(A_CTRL, 32'h3);
    rdchk("t5_abort_start", A_STAT, 32'h08);
    rdchk("t5_ctrl", A_CTRL, 32'h0);

    // abort after the 5th rise of a LEN=32 run
    prep();
    wr(A_DIV, 32'd1);
    wr(A_LEN, 32'd32);
    wr(A_DATA, 32'hDEAD_BEEF);
    wr(A_DATA, 32'h1234_0000);
    wr(A_CTRL, 32'h1);
    seen = 0;
    begin
      logic p;
      p = pc1;
      for (int i = 0; i < 200 && seen < 5; i++) begin
        @(negedge clk);
        if (pc1 && !p) seen++;
        p = pc1;
      end
    end
    chk("t6_five_rises", seen, 32'd5);
    wr(A_CTRL, 32'h2);
    chk("t6_pins", {30'd0, pc1, head1}, 32'd0);
    rdchk("t6_status", A_STAT, 32'h08);

    // tail loopback, LEN=32
    prep();
    loop_en = 1'b1;
    wr(A_DIV, 32'd0);
    wr(A_DATA, 32'h1234_5678);
    wr(A_CTRL, 32'h1);
    mon(100);
    chk("t7_rises", r1, 32'd32);
    rdchk("t7_tail", A_TAIL, 32'h2468_ACF0);
    loop_en = 1'b0;

    // reset in the middle of a run
    prep();
    wr(A_DATA, 32'hCAFE_F00D);
    wr(A_CTRL, 32'hD);
    rdchk("t8_ctrl", A_CTRL, 32'hC);
    mon(6);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t8_rst_pins",
        {27'd0, ack1, pc1, prst1, csel1, head1}, 32'd0);
    chk("t8_rst_dat", rdat1, 32'd0);
    chk("t8_rst_dut2", {28'd0, pc2, prst2, head2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("t8_status", A_STAT, 32'h08);
    rdchk("t8_len", A_LEN, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
